// File: rtl/load_store_align_unit.sv
// Load/store alignment unit between the EX/MEM pipeline register and the data
// memory port. A request is captured and decoded in one cycle. Stores get
// their data lane-shifted with byte enables; loads get their data shifted
// down and sign/zero extended. Memory latency is handled with a
// request/acknowledge handshake, and the pipeline is stalled while busy.
module load_store_align_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [2:0]            funct3_i,
    input  logic [ADDR_W-1:0]     address_i,
    input  logic [DATA_W-1:0]     data2_i,
    output logic                  busy_o,
    output logic                  resp_valid_o,
    output logic [DATA_W-1:0]     out_o,
    output logic [1:0]            fault_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic [ADDR_W-1:0]     mem_address_o,
    output logic [DATA_W/8-1:0]   mem_byte_en_o,
    output logic [DATA_W-1:0]     out_datamem_o,
    input  logic [DATA_W-1:0]     in_datamem_i,
    input  logic                  mem_ack_i
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_ILLEGAL  = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP,
        FAULT_RESP
    } AlignState;

    AlignState state_q, state_d;

    logic              write_q, write_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [OFF_W-1:0]  offset_q, offset_d;
    logic              memRead_q, memRead_d;
    logic              memWrite_q, memWrite_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [NB-1:0]     memBe_q, memBe_d;
    logic [DATA_W-1:0] memWData_q, memWData_d;
    logic              respValid_q, respValid_d;
    logic [1:0]        fault_q, fault_d;
    logic [DATA_W-1:0] outData_q, outData_d;

    logic [OFF_W-1:0]  reqOff;
    logic [2:0]        reqOff3;
    logic              reqIllegal;
    logic              reqMisaligned;
    logic [7:0]        sizeMask8;
    logic [NB-1:0]     sizeMask;
    logic [NB-1:0]     reqByteEn;
    logic [DATA_W-1:0] dataMask;
    logic [DATA_W-1:0] reqStoreData;
    logic [DATA_W-1:0] loadShifted;
    logic [DATA_W-1:0] loadResult;

    // Decode the incoming request: legality of funct3 for the configured
    // width, alignment of the byte offset, and the store lane layout.
    always_comb begin
        reqOff    = address_i[OFF_W-1:0];
        reqOff3   = 3'(reqOff);

        reqIllegal = 1'b1;
        if (req_write_i) begin
            case (funct3_i)
                3'b000, 3'b001, 3'b010: reqIllegal = 1'b0;
                3'b011:                 reqIllegal = (DATA_W != 64);
                default:                reqIllegal = 1'b1;
            endcase
        end else begin
            case (funct3_i)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: reqIllegal = 1'b0;
                3'b011, 3'b110:                         reqIllegal = (DATA_W != 64);
                default:                                reqIllegal = 1'b1;
            endcase
        end

        reqMisaligned = 1'b0;
        case (funct3_i[1:0])
            2'b01:   reqMisaligned = reqOff3[0];
            2'b10:   reqMisaligned = (reqOff3[1:0] != 2'b00);
            2'b11:   reqMisaligned = (reqOff3 != 3'b000);
            default: reqMisaligned = 1'b0;
        endcase

        case (funct3_i[1:0])
            2'b00:   sizeMask8 = 8'h01;
            2'b01:   sizeMask8 = 8'h03;
            2'b10:   sizeMask8 = 8'h0F;
            default: sizeMask8 = 8'hFF;
        endcase
        sizeMask  = NB'(sizeMask8);
        reqByteEn = sizeMask << reqOff;

        dataMask = '0;
        for (int i = 0; i < NB; i++) begin
            dataMask[8*i +: 8] = {8{sizeMask[i]}};
        end
        reqStoreData = (data2_i & dataMask) << {reqOff, 3'b000};
    end

    // Align returned memory data to bit 0 and extend according to the
    // captured funct3; 010 sign-extends on 64-bit and is full width on 32-bit.
    always_comb begin
        loadShifted = in_datamem_i >> {offset_q, 3'b000};
        case (funct3_q)
            3'b000:  loadResult = DATA_W'($signed(loadShifted[7:0]));
            3'b001:  loadResult = DATA_W'($signed(loadShifted[15:0]));
            3'b010:  loadResult = DATA_W'($signed(loadShifted[31:0]));
            3'b100:  loadResult = DATA_W'(loadShifted[7:0]);
            3'b101:  loadResult = DATA_W'(loadShifted[15:0]);
            3'b110:  loadResult = DATA_W'(loadShifted[31:0]);
            default: loadResult = loadShifted;
        endcase
    end

    // Next-state and registered-output logic of the handshake FSM.
    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        funct3_d    = funct3_q;
        offset_d    = offset_q;
        memRead_d   = memRead_q;
        memWrite_d  = memWrite_q;
        memAddr_d   = memAddr_q;
        memBe_d     = memBe_q;
        memWData_d  = memWData_q;
        outData_d   = outData_q;
        respValid_d = 1'b0;
        fault_d     = FAULT_NONE;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    write_d  = req_write_i;
                    funct3_d = funct3_i;
                    offset_d = reqOff;
                    if (reqIllegal) begin
                        respValid_d = 1'b1;
                        fault_d     = FAULT_ILLEGAL;
                        state_d     = FAULT_RESP;
                    end else if (reqMisaligned) begin
                        respValid_d = 1'b1;
                        fault_d     = FAULT_MISALIGN;
                        state_d     = FAULT_RESP;
                    end else begin
                        memRead_d  = ~req_write_i;
                        memWrite_d = req_write_i;
                        memAddr_d  = {address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        memBe_d    = req_write_i ? reqByteEn : '0;
                        memWData_d = req_write_i ? reqStoreData : '0;
                        state_d    = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (mem_ack_i) begin
                    memRead_d   = 1'b0;
                    memWrite_d  = 1'b0;
                    memAddr_d   = '0;
                    memBe_d     = '0;
                    memWData_d  = '0;
                    respValid_d = 1'b1;
                    if (!write_q) begin
                        outData_d = loadResult;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            FAULT_RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            funct3_q    <= 3'b000;
            offset_q    <= '0;
            memRead_q   <= 1'b0;
            memWrite_q  <= 1'b0;
            memAddr_q   <= '0;
            memBe_q     <= '0;
            memWData_q  <= '0;
            respValid_q <= 1'b0;
            fault_q     <= FAULT_NONE;
            outData_q   <= '0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            funct3_q    <= funct3_d;
            offset_q    <= offset_d;
            memRead_q   <= memRead_d;
            memWrite_q  <= memWrite_d;
            memAddr_q   <= memAddr_d;
            memBe_q     <= memBe_d;
            memWData_q  <= memWData_d;
            respValid_q <= respValid_d;
            fault_q     <= fault_d;
            outData_q   <= outData_d;
        end
    end

    assign req_ready_o   = (state_q == IDLE);
    assign busy_o        = (state_q != IDLE);
    assign resp_valid_o  = respValid_q;
    assign fault_o       = fault_q;
    assign out_o         = outData_q;
    assign mem_read_o    = memRead_q;
    assign mem_write_o   = memWrite_q;
    assign mem_address_o = memAddr_q;
    assign mem_byte_en_o = memBe_q;
    assign out_datamem_o = memWData_q;

endmodule
